biquad_coeff_sequencer: RTL

- Wishbone master that loads a table of biquad coefficient writes into the trigger chain's biquad register space.
- Table entries are {address, data} pairs in an external 1-cycle-latency BRAM.
- After the last write it pulses the biquad reset so the new coefficients take effect from a clean filter state.
- Sits between the PS-side control logic and the trigger chain's Wishbone target. It replaces hand-sequenced PS writes.

---
 rtl/biquad_coeff_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/biquad_coeff_sequencer.sv
// biquad_coeff_sequencer
//   Wishbone master that copies a table of {address, data} coefficient
//   writes into the trigger chain's biquad register space. The table is
//   held in an external BRAM with one cycle of read latency. After the last
//   write, the block pulses reset_BQ_o so the new coefficients start from a
//   clean filter state.
//
// Ports
//   aclk, aresetn          clock (rising edge) / async active-low reset
//   start_i, count_i       load request and entry count (sampled in IDLE)
//   busy_o, done_o, err_o  status: busy, success pulse, sticky error
//   err_idx_o              index of the failing entry while err_o is high
//   tbl_en_o, tbl_addr_o   table read port
//   tbl_dat_i              table entry {address, data}
//   wb_*                   Wishbone master write port
//   reset_BQ_o             biquad state reset pulse (RST_CYCLES wide)
module biquad_coeff_sequencer #(
  parameter int WB_AW      = 22,
  parameter int WB_DW      = 32,
  parameter int TBL_AW     = 6,
  parameter int TIMEOUT    = 255,
  parameter int RST_CYCLES = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start_i,
  input  logic [TBL_AW:0]        count_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [TBL_AW-1:0]      err_idx_o,
  output logic                   tbl_en_o,
  output logic [TBL_AW-1:0]      tbl_addr_o,
  input  logic [WB_AW+WB_DW-1:0] tbl_dat_i,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [WB_AW-1:0]       wb_adr_o,
  output logic [WB_DW-1:0]       wb_dat_o,
  output logic [WB_DW/8-1:0]     wb_sel_o,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i,
  output logic                   reset_BQ_o
);

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int PC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  // Largest table size; larger requested counts are clamped to this.
  localparam logic [TBL_AW:0] MAX_CNT = {1'b1, {TBL_AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_ERROR = 3'd4,
    S_PULSE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state_r;
  // idx/count are one bit wider than the table address so a full table
  // (count == 2^TBL_AW) terminates on idx == count without wrapping.
  logic [TBL_AW:0]   idx_r;
  logic [TBL_AW:0]   count_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [PC_W-1:0]   pulse_cnt_r;
  logic [TBL_AW:0]   idx_inc_s;

  assign idx_inc_s = idx_r + {{TBL_AW{1'b0}}, 1'b1};

  // Sequencer FSM; every output is registered here.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= S_IDLE;
      idx_r       <= '0;
      count_r     <= '0;
      to_cnt_r    <= '0;
      pulse_cnt_r <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_idx_o   <= '0;
      tbl_en_o    <= 1'b0;
      tbl_addr_o  <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      reset_BQ_o  <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      done_o   <= 1'b0;
      tbl_en_o <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            busy_o    <= 1'b1;
            err_o     <= 1'b0;
            err_idx_o <= '0;
            idx_r     <= '0;
            count_r   <= (count_i > MAX_CNT) ? MAX_CNT : count_i;
            if (count_i == '0) begin
              state_r     <= S_PULSE;
              reset_BQ_o  <= 1'b1;
              pulse_cnt_r <= '0;
            end else begin
              state_r    <= S_FETCH;
              tbl_en_o   <= 1'b1;
              tbl_addr_o <= '0;
            end
          end else begin
            busy_o <= 1'b0;
          end
        end
        S_FETCH: begin
          // BRAM samples the address at the end of this cycle.
          state_r <= S_LATCH;
        end
        S_LATCH: begin
          wb_adr_o <= tbl_dat_i[WB_AW+WB_DW-1:WB_DW];
          wb_dat_o <= tbl_dat_i[WB_DW-1:0];
          wb_sel_o <= '1;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b1;
          to_cnt_r <= '0;
          state_r  <= S_WRITE;
        end
        S_WRITE: begin
          // err outranks ack when both arrive in the same cycle.
          if (wb_err_i || (!wb_ack_i && (to_cnt_r == TO_W'(TIMEOUT - 1)))) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            err_o     <= 1'b1;
            err_idx_o <= idx_r[TBL_AW-1:0];
            state_r   <= S_ERROR;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            idx_r    <= idx_inc_s;
            if (idx_inc_s == count_r) begin
              state_r     <= S_PULSE;
              reset_BQ_o  <= 1'b1;
              pulse_cnt_r <= '0;
            end else begin
              state_r    <= S_FETCH;
              tbl_en_o   <= 1'b1;
              tbl_addr_o <= idx_inc_s[TBL_AW-1:0];
            end
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        S_ERROR: begin
          busy_o  <= 1'b0;
          state_r <= S_IDLE;
        end
        S_PULSE: begin
          if (pulse_cnt_r == PC_W'(RST_CYCLES - 1)) begin
            reset_BQ_o <= 1'b0;
            done_o     <= 1'b1;
            state_r    <= S_DONE;
          end else begin
            pulse_cnt_r <= pulse_cnt_r + PC_W'(1);
          end
        end
        S_DONE: begin
          busy_o  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_o     <= 1'b0;
          wb_cyc_o   <= 1'b0;
          wb_stb_o   <= 1'b0;
          wb_we_o    <= 1'b0;
          wb_sel_o   <= '0;
          reset_BQ_o <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
